// File: rtl/rv32v_vmem_sequencer.sv
// Vector memory micro-op sequencer: walks up to NUM_LANES elements through the scalar LSC port.
// Build option RV32V_STRIDED_EN: element stride comes from the stride port; otherwise unit-stride.
module rv32v_vmem_sequencer #(
    parameter int NUM_LANES = 4
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        start,
    input  logic                        is_store,
    input  logic [31:0]                 base_addr,
    input  logic [31:0]                 stride,
    input  logic [1:0]                  eew,
    input  logic [$clog2(NUM_LANES):0]  vcount,
    input  logic [NUM_LANES-1:0]        lane_mask,
    input  logic [NUM_LANES*32-1:0]     store_data,
    input  logic                        flush,
    input  logic                        mem_busy,
    input  logic                        mem_error,
    input  logic [31:0]                 mem_rdata,
    output logic                        mem_ren,
    output logic                        mem_wen,
    output logic [31:0]                 mem_addr,
    output logic [31:0]                 mem_wdata,
    output logic [1:0]                  mem_eew,
    output logic [NUM_LANES-1:0]        lane_wen,
    output logic [31:0]                 lane_wdata,
    output logic                        stall,
    output logic                        done,
    output logic                        fault,
    output logic [31:0]                 fault_addr
);

    localparam int IW = $clog2(NUM_LANES);
    localparam int CW = IW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t                 state, state_nx;
    logic [IW-1:0]          idx, idx_nx;
    logic [31:0]            addr_q, addr_nx;
    logic [31:0]            stride_q, stride_nx;
    logic [31:0]            fault_addr_q, fault_addr_nx;
    logic [1:0]             eew_q, eew_nx;
    logic [CW-1:0]          vcount_q, vcount_nx;
    logic [NUM_LANES-1:0]   mask_q, mask_nx;
    logic                   is_store_q, is_store_nx;
    logic                   fault_q, fault_nx;

    logic [31:0] stride_sel;
`ifdef RV32V_STRIDED_EN
    assign stride_sel = stride;
`else
    assign stride_sel = 32'(1) << eew;
    logic unused_stride;
    assign unused_stride = ^stride;
`endif

    logic lane_active, misaligned, req, complete, last, advance;

    assign lane_active = mask_q[idx];
    assign misaligned  = (eew_q == 2'd3)
                       | ((eew_q == 2'd1) & addr_q[0])
                       | ((eew_q == 2'd2) & (|addr_q[1:0]));
    assign req         = (state == ISSUE) & lane_active & ~misaligned & ~flush;
    assign complete    = req & ~mem_busy;
    assign last        = ({1'b0, idx} == (vcount_q - CW'(1)));

    assign mem_ren    = req & ~is_store_q;
    assign mem_wen    = req & is_store_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = mem_wen ? store_data[32*idx +: 32] : 32'd0;
    assign mem_eew    = eew_q;
    // Load data steers straight to the lane in its completion cycle; flush already cleared req.
    assign lane_wen   = (complete & ~is_store_q & ~mem_error) ? (NUM_LANES'(1) << idx) : '0;
    assign lane_wdata = mem_rdata;
    assign stall      = ((state == IDLE) & start) | (state == ISSUE);
    assign done       = (state == DONE) & ~flush;
    assign fault      = done & fault_q;
    assign fault_addr = fault_addr_q;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        state_nx      = state;
        idx_nx        = idx;
        addr_nx       = addr_q;
        stride_nx     = stride_q;
        fault_addr_nx = fault_addr_q;
        eew_nx        = eew_q;
        vcount_nx     = vcount_q;
        mask_nx       = mask_q;
        is_store_nx   = is_store_q;
        fault_nx      = fault_q;
        advance       = 1'b0;

        case (state)
            IDLE: begin
                if (start && !flush) begin
                    is_store_nx = is_store;
                    eew_nx      = eew;
                    vcount_nx   = vcount;
                    mask_nx     = lane_mask;
                    stride_nx   = stride_sel;
                    addr_nx     = base_addr;
                    idx_nx      = '0;
                    fault_nx    = 1'b0;
                    state_nx    = (vcount == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (flush) begin
                    state_nx = IDLE;
                end else if (!lane_active) begin
                    advance = 1'b1;
                end else if (misaligned) begin
                    fault_nx      = 1'b1;
                    fault_addr_nx = addr_q;
                    state_nx      = DONE;
                end else if (complete) begin
                    if (mem_error) begin
                        fault_nx      = 1'b1;
                        fault_addr_nx = addr_q;
                        state_nx      = DONE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        if (advance) begin
            idx_nx   = idx + IW'(1);
            addr_nx  = addr_q + stride_q;
            state_nx = last ? DONE : ISSUE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            idx          <= '0;
            addr_q       <= '0;
            stride_q     <= '0;
            fault_addr_q <= '0;
            eew_q        <= '0;
            vcount_q     <= '0;
            mask_q       <= '0;
            is_store_q   <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state        <= state_nx;
            idx          <= idx_nx;
            addr_q       <= addr_nx;
            stride_q     <= stride_nx;
            fault_addr_q <= fault_addr_nx;
            eew_q        <= eew_nx;
            vcount_q     <= vcount_nx;
            mask_q       <= mask_nx;
            is_store_q   <= is_store_nx;
            fault_q      <= fault_nx;
        end
    end

endmodule

// File: tb/tb_rv32v_vmem_sequencer.sv
// Scoreboard bench for rv32v_vmem_sequencer: reference model queues expected bus
// requests, lane writes and completions; a monitor and a bus responder consume them.
module tb_rv32v_vmem_sequencer;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         start = 1'b0, is_store = 1'b0, flush = 1'b0;
    logic [31:0]  base_addr = '0, stride = '0, mem_rdata = '0;
    logic [1:0]   eew = '0;
    logic [2:0]   vcount = '0;
    logic [3:0]   lane_mask = '0;
    logic [127:0] store_data = '0;
    logic         mem_busy = 1'b0, mem_error = 1'b0;

    logic         mem_ren, mem_wen, stall, done, fault;
    logic [31:0]  mem_addr, mem_wdata, lane_wdata, fault_addr;
    logic [1:0]   mem_eew;
    logic [3:0]   lane_wen;

    rv32v_vmem_sequencer #(.NUM_LANES(4)) dut (
        .CLK(CLK), .RST(RST), .start(start), .is_store(is_store),
        .base_addr(base_addr), .stride(stride), .eew(eew), .vcount(vcount),
        .lane_mask(lane_mask), .store_data(store_data), .flush(flush),
        .mem_busy(mem_busy), .mem_error(mem_error), .mem_rdata(mem_rdata),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_eew(mem_eew), .lane_wen(lane_wen),
        .lane_wdata(lane_wdata), .stall(stall), .done(done), .fault(fault),
        .fault_addr(fault_addr)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [31:0] addr; logic wr; logic [31:0] wdata; logic [1:0] eew; } req_t;
    typedef struct { int lane; logic [31:0] data; } lane_t;
    typedef struct { logic flt; logic [31:0] faddr; int cyc; } done_t;
    typedef struct { int waits; logic err; logic [31:0] rd; } resp_t;
    typedef struct {
        logic st; logic [31:0] base; logic [31:0] strd; logic [1:0] eew; int vc;
        logic [3:0] mask; logic [3:0][1:0] waits; logic [3:0] errs;
        logic [3:0][31:0] rd; logic [127:0] sd;
    } op_t;

    req_t  req_q[$];
    lane_t lane_q[$];
    done_t done_q[$];
    resp_t resp_q[$];

    int          n_vec = 0, n_err = 0, cyc = 0, last_done_cyc = 0;
    logic [31:0] model_fault_addr = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_queues();
        req_q.delete(); lane_q.delete(); done_q.delete(); resp_q.delete();
    endtask

    // Reference model: element k lives at base + k*stride; walk lanes and accumulate cost.
    task automatic plan(input op_t o);
        logic [31:0] se, a, fa;
        int t;
        logic flt;
`ifdef RV32V_STRIDED_EN
        se = o.strd;
`else
        se = 32'(1) << o.eew;
`endif
        t = 1; flt = 1'b0; fa = '0;
        for (int k = 0; k < o.vc; k++) begin
            a = o.base + 32'(k) * se;
            if (!o.mask[k]) begin t++; continue; end
            if (o.eew == 2'd3 || (a % (32'(1) << o.eew)) != 0) begin
                t++; flt = 1'b1; fa = a; break;
            end
            req_q.push_back('{a, o.st, o.sd[32*k +: 32], o.eew});
            resp_q.push_back('{int'(o.waits[k]), o.errs[k], o.rd[k]});
            t += int'(o.waits[k]) + 1;
            if (o.errs[k]) begin flt = 1'b1; fa = a; break; end
            if (!o.st) lane_q.push_back('{k, o.rd[k]});
        end
        if (flt) model_fault_addr = fa;
        done_q.push_back('{flt, model_fault_addr, cyc + t});
    endtask

    function automatic op_t make_op(input logic st, input logic [31:0] base, input logic [31:0] strd,
                                    input logic [1:0] e, input int vc, input logic [3:0] mask);
        op_t o;
        o.st = st; o.base = base; o.strd = strd; o.eew = e; o.vc = vc; o.mask = mask;
        o.waits = '0; o.errs = '0;
        for (int k = 0; k < 4; k++) begin
            o.rd[k] = $urandom;
            o.sd[32*k +: 32] = $urandom;
        end
        return o;
    endfunction

    task automatic wait_done();
        int budget = 200;
        while (done_q.size() != 0 && budget > 0) begin
            @(negedge CLK);
            budget--;
        end
        check("done_within_budget", done_q.size(), 0);
        if (done_q.size() != 0) clear_queues();
        #2;
        check("stall_after_done", stall, 1'b0);
        check("req_q_drained", req_q.size(), 0);
        check("lane_q_drained", lane_q.size(), 0);
        check("resp_q_drained", resp_q.size(), 0);
    endtask

    task automatic drive_op(input op_t o);
        is_store = o.st; base_addr = o.base; stride = o.strd; eew = o.eew;
        vcount = 3'(o.vc); lane_mask = o.mask; store_data = o.sd; start = 1'b1;
    endtask

    task automatic run_op(input op_t o, output int c0);
        @(negedge CLK);
        drive_op(o);
        c0 = cyc;
        plan(o);
        #2 check("stall_at_start", stall, 1'b1);
        @(negedge CLK) start = 1'b0;
        wait_done();
    endtask

    // Bus responder: holds mem_busy for the element's wait count, then completes.
    initial begin
        resp_t cur;
        int    remain = 0;
        bit    active = 1'b0;
        cur = '{0, 1'b0, 32'd0};
        forever begin
            @(negedge CLK);
            #1;
            if (RST || !(mem_ren || mem_wen)) begin
                active = 1'b0; mem_busy = 1'b0; mem_error = 1'b0;
            end else begin
                if (!active) begin
                    if (resp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_request: addr 0x%08h seen, none expected", mem_addr);
                        cur = '{0, 1'b0, 32'd0};
                    end else begin
                        cur = resp_q.pop_front();
                    end
                    active = 1'b1;
                    remain = cur.waits;
                end
                if (remain > 0) begin
                    mem_busy = 1'b1; mem_error = 1'b0; remain--;
                end else begin
                    mem_busy = 1'b0; mem_error = cur.err; mem_rdata = cur.rd; active = 1'b0;
                end
            end
        end
    end

    // Monitor: compares every completion, lane write and done pulse against the queues.
    initial begin
        req_t  e;
        lane_t l;
        done_t d;
        forever begin
            @(negedge CLK);
            #3;
            if (!RST) begin
                if ((mem_ren || mem_wen) && !mem_busy) begin
                    if (req_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_completion: addr 0x%08h", mem_addr);
                    end else begin
                        e = req_q.pop_front();
                        check("req_addr", mem_addr, e.addr);
                        check("req_is_write", mem_wen, e.wr);
                        check("req_is_read", mem_ren, !e.wr);
                        check("req_eew", mem_eew, e.eew);
                        if (e.wr) check("req_wdata", mem_wdata, e.wdata);
                    end
                end
                if (lane_wen != 4'd0) begin
                    if (lane_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_lane_wen: got %b", lane_wen);
                    end else begin
                        l = lane_q.pop_front();
                        check("lane_wen", lane_wen, 4'(1) << l.lane);
                        check("lane_wdata", lane_wdata, l.data);
                    end
                end
                if (done) begin
                    if (done_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_done at cycle %0d", cyc);
                    end else begin
                        d = done_q.pop_front();
                        check("done_cycle", cyc, d.cyc);
                        check("fault", fault, d.flt);
                        check("fault_addr", fault_addr, d.faddr);
                        check("stall_in_done", stall, 1'b0);
                    end
                    last_done_cyc = cyc;
                end else if (fault) begin
                    n_vec++; n_err++;
                    $display("FAIL fault_without_done at cycle %0d", cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t o;
        int  c0;

        repeat (3) @(negedge CLK);
        #2;
        check("rst_stall", stall, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_fault", fault, 1'b0);
        check("rst_fault_addr", fault_addr, 32'd0);
        check("rst_mem_ren", mem_ren, 1'b0);
        check("rst_mem_addr", mem_addr, 32'd0);
        @(negedge CLK) RST = 1'b0;

        // Unit-stride load, zero wait: done five cycles after start.
        o = make_op(1'b0, 32'h100, 32'd4, 2'd2, 4, 4'b1111);
        run_op(o, c0);
        check("unit_load_latency", last_done_cyc - c0, 5);

        // Misaligned word element: no request, fault two cycles after start.
        o = make_op(1'b0, 32'h102, 32'd4, 2'd2, 4, 4'b1111);
        run_op(o, c0);
        check("misaligned_latency", last_done_cyc - c0, 2);
        check("misaligned_fault_addr", fault_addr, 32'h102);

        // Bus error on element 1 of a load.
        o = make_op(1'b0, 32'h300, 32'd4, 2'd2, 4, 4'b1111);
        o.errs = 4'b0010;
        run_op(o, c0);
        check("buserr_fault_addr", fault_addr, 32'h304);

`ifdef RV32V_STRIDED_EN
        // Strided store, negative stride, lane 2 masked, element 0 busy for two cycles.
        o = make_op(1'b1, 32'h200, 32'hFFFF_FFF8, 2'd2, 4, 4'b1011);
        o.waits[0] = 2'd2;
        run_op(o, c0);
        check("strided_store_latency", last_done_cyc - c0, 7);
`endif

        // Flush while element 2 is waiting on the bus.
        o = make_op(1'b0, 32'h100, 32'd4, 2'd2, 4, 4'b1111);
        @(negedge CLK);
        drive_op(o);
        req_q.push_back('{32'h100, 1'b0, 32'd0, 2'd2});
        req_q.push_back('{32'h104, 1'b0, 32'd0, 2'd2});
        resp_q.push_back('{0, 1'b0, o.rd[0]});
        resp_q.push_back('{0, 1'b0, o.rd[1]});
        resp_q.push_back('{3, 1'b0, 32'd0});
        lane_q.push_back('{0, o.rd[0]});
        lane_q.push_back('{1, o.rd[1]});
        @(negedge CLK) start = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        #2;
        check("flush_pre_ren", mem_ren, 1'b1);
        check("flush_pre_addr", mem_addr, 32'h108);
        @(negedge CLK) flush = 1'b1;
        #2;
        check("flush_ren", mem_ren, 1'b0);
        check("flush_lane_wen", lane_wen, 4'd0);
        check("flush_done", done, 1'b0);
        @(negedge CLK) flush = 1'b0;
        #2;
        check("flush_idle_stall", stall, 1'b0);
        check("flush_req_q", req_q.size(), 0);
        check("flush_lane_q", lane_q.size(), 0);
        o = make_op(1'b0, 32'h500, 32'd2, 2'd1, 3, 4'b0111);
        run_op(o, c0);
        check("after_flush_latency", last_done_cyc - c0, 4);

        // Reset in the middle of ISSUE, then a zero-length op.
        o = make_op(1'b1, 32'h40, 32'd4, 2'd2, 4, 4'b1111);
        @(negedge CLK);
        drive_op(o);
        resp_q.push_back('{3, 1'b0, 32'd0});
        @(negedge CLK) start = 1'b0;
        @(negedge CLK) RST = 1'b1;
        #2;
        check("midrst_mem_ren", mem_ren, 1'b0);
        check("midrst_mem_wen", mem_wen, 1'b0);
        check("midrst_mem_wdata", mem_wdata, 32'd0);
        check("midrst_mem_addr", mem_addr, 32'd0);
        check("midrst_mem_eew", mem_eew, 2'd0);
        check("midrst_lane_wen", lane_wen, 4'd0);
        check("midrst_stall", stall, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_fault_addr", fault_addr, 32'd0);
        clear_queues();
        model_fault_addr = '0;
        @(negedge CLK) RST = 1'b0;
        o = make_op(1'b0, 32'h80, 32'd4, 2'd2, 0, 4'b1111);
        run_op(o, c0);
        check("vcount0_latency", last_done_cyc - c0, 1);

        // Randomized ops against the reference model.
        for (int n = 0; n < 80; n++) begin
            logic [1:0]  e;
            logic [31:0] b, s;
            e = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            b = $urandom;
            if ($urandom_range(0, 7) != 0) b = b & ~((32'(1) << e) - 32'd1);
            s = 32'($urandom_range(0, 15)) - 32'd8;
            s = ($urandom_range(0, 7) == 0) ? s : (s << e);
            o = make_op(1'($urandom), b, s, e, $urandom_range(0, 4), 4'($urandom));
            for (int k = 0; k < 4; k++) begin
                o.waits[k] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
                o.errs[k]  = ($urandom_range(0, 11) == 0);
            end
            run_op(o, c0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
